// File: rtl/ddr_tx.sv
// DDR transmit path: a small word FIFO feeding a posedge/negedge output pair.
// Each popped byte appears on ddr_out as its rise nibble (clk high), then its fall nibble (clk low).
module ddr_tx #(
    parameter int DEPTH     = 4,
    parameter int START_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_en,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic [3:0]               ddr_out,
    output logic                     ddr_valid,
    output logic [3:0]               q_rise,
    output logic [3:0]               q_fall,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [3:0]      fall_stage_r;
    logic            push_s;
    logic            pop_s;

    assign in_ready = (fifo_count != CW'(DEPTH));

    // Handshake decode; a pop only sees words already stored before this edge.
    always_comb begin
        push_s = in_valid && in_ready;
        pop_s  = (state_r == RUN) && tx_en && (fifo_count != {CW{1'b0}});
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_count <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmit state machine and posedge output stage; outputs idle at zero without a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ddr_valid    <= 1'b0;
            q_rise       <= 4'h0;
            fall_stage_r <= 4'h0;
            underrun     <= 1'b0;
        end else begin
            ddr_valid    <= 1'b0;
            q_rise       <= 4'h0;
            fall_stage_r <= 4'h0;
            case (state_r)
                IDLE: begin
                    if (tx_en) begin
                        state_r <= FILL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    if (!tx_en) begin
                        state_r <= IDLE;
                    end else if (fifo_count >= CW'(START_LVL)) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= FILL;
                    end
                end
                RUN: begin
                    if (!tx_en) begin
                        state_r <= IDLE;
                    end else if (fifo_count == {CW{1'b0}}) begin
                        underrun <= 1'b1;
                        state_r  <= FILL;
                    end else begin
                        ddr_valid    <= 1'b1;
                        q_rise       <= mem_r[rd_ptr_r][3:0];
                        fall_stage_r <= mem_r[rd_ptr_r][7:4];
                        state_r      <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Negedge stage re-times the fall nibble for the low phase of the same cycle.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_fall <= 4'h0;
        end else begin
            q_fall <= fall_stage_r;
        end
    end

    // Phase mux onto the DDR pins
    always_comb begin
        if (clk) begin
            ddr_out = q_rise;
        end else begin
            ddr_out = q_fall;
        end
    end

endmodule
